// File: rtl/adder_subtractor_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, carry held between chunks.
// Result and flags are published together with the one-cycle done pulse.
module adder_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int NCYC = WIDTH / CHUNK;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NCYC - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic [WIDTH-1:0] w_chunk_ext;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;
    logic             w_ovf;

    assign {w_chunk_cout, w_chunk_sum} = {1'b0, r_a[CHUNK-1:0]}
                                       + {1'b0, r_b[CHUNK-1:0]}
                                       + {{CHUNK{1'b0}}, r_carry};

    always_comb begin
        w_chunk_ext              = '0;
        w_chunk_ext[CHUNK-1:0]   = w_chunk_sum;
    end

    // Operands shift right each chunk; new sum bits enter from the top so the
    // accumulated word is aligned once the last chunk lands.
    assign w_sum_next = (r_sum >> CHUNK) | (w_chunk_ext << (WIDTH - CHUNK));
    assign w_last     = (r_cnt == '0);
    assign w_ovf      = (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1] ^ sub;
                        r_sum   <= '0;
                        r_cnt   <= CNT_LOAD;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_chunk_cout;
                    r_sum   <= w_sum_next;
                    r_cnt   <= r_cnt - CW'(1);
                    if (w_last) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= w_sum_next;
                        carry    <= w_chunk_cout;
                        overflow <= w_ovf;
                        zero     <= (w_sum_next == '0);
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_subtractor_seq.sv
// Bench for adder_subtractor_seq: CHUNK=4, 1 and 16 builds checked against an integer
// arithmetic model, with directed corner cases, ignored-start, back-to-back and reset abort.
module tb_adder_subtractor_seq;
    logic        clk;
    logic        rst;
    logic        sub_in;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] res_v   [3];
    logic        carry_v [3];
    logic        ovf_v   [3];
    logic        zero_v  [3];
    logic [18:0] prev_v  [3];

    int checks = 0;
    int errors = 0;

    adder_subtractor_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_in), .a(a_in), .b(b_in),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .carry(carry_v[0]),
        .overflow(ovf_v[0]), .zero(zero_v[0]));

    adder_subtractor_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_in), .a(a_in), .b(b_in),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .carry(carry_v[1]),
        .overflow(ovf_v[1]), .zero(zero_v[1]));

    adder_subtractor_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_in), .a(a_in), .b(b_in),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .carry(carry_v[2]),
        .overflow(ovf_v[2]), .zero(zero_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] flags_of(input int idx);
        return {carry_v[idx], ovf_v[idx], zero_v[idx], res_v[idx]};
    endfunction

    // Reference: plain integer arithmetic, packed as {carry, overflow, zero, result}.
    function automatic logic [18:0] model(input logic [15:0] opa, input logic [15:0] opb,
                                          input logic osub);
        int ua, ub, sa, sb, sr;
        logic [15:0] er;
        logic ec, eo;
        ua = opa;
        ub = opb;
        sa = $signed(opa);
        sb = $signed(opb);
        sr = osub ? (sa - sb) : (sa + sb);
        eo = (sr > 32767) || (sr < -32768);
        ec = osub ? (ua >= ub) : ((ua + ub) > 65535);
        er = osub ? 16'(ua - ub) : 16'(ua + ub);
        return {ec, eo, (er == 16'h0000), er};
    endfunction

    task automatic do_op(input int idx, input logic [15:0] opa, input logic [15:0] opb,
                         input logic osub, input int lat, input bit mid, input bit b2b,
                         input string tag, output logic [18:0] got);
        int n;
        logic [18:0] exp;
        exp = model(opa, opb, osub);
        @(negedge clk);
        if (b2b) chk({tag, "_b2b_done"}, done_v[idx], 1);
        a_in = opa;
        b_in = opb;
        sub_in = osub;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        sub_in = 1'($urandom);
        chk({tag, "_busy"}, {busy_v[idx], done_v[idx]}, 2'b10);
        chk({tag, "_hold"}, flags_of(idx), prev_v[idx]);
        n = 0;
        while (n < lat + 4) begin
            @(posedge clk);
            #1;
            n++;
            if (done_v[idx]) break;
            start_v[idx] = (mid && n == 1);
        end
        start_v[idx] = 1'b0;
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_at_done"}, busy_v[idx], 0);
        got = flags_of(idx);
        chk({tag, "_result_flags"}, got, exp);
        prev_v[idx] = exp;
    endtask

    initial begin
        logic [18:0] got;
        logic [15:0] ra, rb;
        rst = 1'b1;
        a_in = '0;
        b_in = '0;
        sub_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            prev_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk("reset_state", {busy_v[i], done_v[i], flags_of(i)}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(0, 16'h1234, 16'h1111, 1'b0, 4, 0, 0, "t1_add", got);
        chk("t1_const", got, {3'b000, 16'h2345});
        do_op(0, 16'h0005, 16'h0007, 1'b1, 4, 0, 1, "t2_borrow", got);
        chk("t2a_const", got, {3'b000, 16'hFFFE});
        do_op(0, 16'h0007, 16'h0007, 1'b1, 4, 0, 1, "t2_equal", got);
        chk("t2b_const", got, {3'b101, 16'h0000});
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 4, 0, 1, "t3_ovf", got);
        chk("t3a_const", got, {3'b010, 16'h8000});
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 4, 0, 1, "t3_wrap", got);
        chk("t3b_const", got, {3'b101, 16'h0000});
        do_op(0, 16'h0102, 16'h0304, 1'b0, 4, 1, 1, "t4_ignore", got);
        do_op(0, 16'hAAAA, 16'h5555, 1'b1, 4, 0, 1, "t4_backtoback", got);

        // Abort an operation in its second RUN cycle; nothing may complete afterwards.
        @(negedge clk);
        a_in = 16'h4321;
        b_in = 16'h1111;
        sub_in = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_reset_async", {busy_v[0], done_v[0], flags_of(0)}, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (done_v[0] || busy_v[0]) seen++;
            end
            chk("t5_no_done_after_abort", seen, 0);
        end
        for (int i = 0; i < 3; i++) prev_v[i] = '0;
        do_op(0, 16'h8000, 16'h0001, 1'b1, 4, 0, 0, "t5_fresh", got);

        for (int i = 0; i < 200; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            do_op(0, ra, rb, 1'($urandom), 4, (i % 7) == 0, 1, "rand_c4", got);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            do_op(1, ra, rb, 1'($urandom), 16, (i % 5) == 0, i > 0, "rand_c1", got);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'(-int'(ra)) : 16'($urandom);
            do_op(2, ra, rb, 1'($urandom), 1, 0, i > 0, "rand_c16", got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
